// File: rtl/idex_stage_if.sv
// ID/EX stage bundle: decode-side inputs, EX-side outputs,
// and the valid/ready/flush handshake between them.
interface idex_stage_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               in_valid_i;
    logic               in_ready_o;
    logic               out_valid_o;
    logic               out_ready_i;
    logic               flush_i;
    logic [XLEN-1:0]    rs1_data_i;
    logic [XLEN-1:0]    rs2_data_i;
    logic [XLEN-1:0]    imm_i;
    logic [RADDR_W-1:0] rs1_addr_i;
    logic [RADDR_W-1:0] rs2_addr_i;
    logic [RADDR_W-1:0] rd_addr_i;
    logic [6:0]         opcode_i;
    logic [2:0]         funct3_i;
    logic [6:0]         funct7_i;
    logic [1:0]         alu_op_i;
    logic               alu_src_i;
    logic [1:0]         mem_i;
    logic               wb_i;
    logic [XLEN-1:0]    val1_o;
    logic [XLEN-1:0]    val2_o;
    logic [XLEN-1:0]    imm_o;
    logic [RADDR_W-1:0] rs1_addr_o;
    logic [RADDR_W-1:0] rs2_addr_o;
    logic [RADDR_W-1:0] rd_addr_o;
    logic [3:0]         alu_ctrl_o;
    logic               alu_src_o;
    logic [1:0]         mem_o;
    logic               wb_o;
    logic               illegal_o;

    modport slave (
        input  in_valid_i, out_ready_i, flush_i,
        input  rs1_data_i, rs2_data_i, imm_i,
        input  rs1_addr_i, rs2_addr_i, rd_addr_i,
        input  opcode_i, funct3_i, funct7_i,
        input  alu_op_i, alu_src_i, mem_i, wb_i,
        output in_ready_o, out_valid_o,
        output val1_o, val2_o, imm_o,
        output rs1_addr_o, rs2_addr_o, rd_addr_o,
        output alu_ctrl_o, alu_src_o, mem_o, wb_o,
        output illegal_o
    );

    modport master (
        output in_valid_i, out_ready_i, flush_i,
        output rs1_data_i, rs2_data_i, imm_i,
        output rs1_addr_i, rs2_addr_i, rd_addr_i,
        output opcode_i, funct3_i, funct7_i,
        output alu_op_i, alu_src_i, mem_i, wb_i,
        input  in_ready_o, out_valid_o,
        input  val1_o, val2_o, imm_o,
        input  rs1_addr_o, rs2_addr_o, rd_addr_o,
        input  alu_ctrl_o, alu_src_o, mem_o, wb_o,
        input  illegal_o
    );
endinterface

// File: rtl/idex_stage.sv
// ID/EX pipeline register with valid/ready stall, flush bubble
// and registered RV32I(+MUL) ALU control decode.
module idex_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter bit MUL_EN  = 1'b1
) (
    input logic          clk_i,
    input logic          rst_i,
    idex_stage_if.slave  bus
);
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;
    localparam logic [3:0] ALU_MUL   = 4'b1111;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_STD = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    val1;
        logic [XLEN-1:0]    val2;
        logic [XLEN-1:0]    imm;
        logic [RADDR_W-1:0] rs1;
        logic [RADDR_W-1:0] rs2;
        logic [RADDR_W-1:0] rd;
        logic [3:0]         ctrl;
        logic               src;
        logic [1:0]         mem;
        logic               wb;
        logic               ill;
    } idex_t;

    idex_t      ex_q, ex_d;
    logic [3:0] dec_ctrl;
    logic       dec_ill;
    logic       is_imm;
    logic       shamt_ok;
    logic       load;

    assign is_imm   = (bus.opcode_i == OP_IMM);
    assign shamt_ok = (bus.funct7_i == F7_STD) ||
                      (bus.funct7_i == F7_ALT);

    always_comb begin
        dec_ctrl = ALU_ADD;
        dec_ill  = 1'b0;
        unique case (1'b1)
            (bus.alu_op_i == 2'b00): dec_ctrl = ALU_ADD;
            (bus.alu_op_i == 2'b01): dec_ctrl = ALU_SUB;
            (bus.alu_op_i == 2'b11): dec_ctrl = ALU_PASSB;
            (bus.alu_op_i == 2'b10 && is_imm): begin
                case (bus.funct3_i)
                    3'b000: dec_ctrl = ALU_ADD;
                    3'b001: begin
                        dec_ctrl = shamt_ok ? ALU_SLL : ALU_ADD;
                        dec_ill  = !shamt_ok;
                    end
                    3'b010: dec_ctrl = ALU_SLT;
                    3'b011: dec_ctrl = ALU_SLTU;
                    3'b100: dec_ctrl = ALU_XOR;
                    3'b101: begin
                        dec_ctrl = !shamt_ok       ? ALU_ADD :
                                   bus.funct7_i[5] ? ALU_SRA : ALU_SRL;
                        dec_ill  = !shamt_ok;
                    end
                    3'b110: dec_ctrl = ALU_OR;
                    default: dec_ctrl = ALU_AND;
                endcase
            end
            (bus.alu_op_i == 2'b10 && !is_imm): begin
                case ({bus.funct7_i, bus.funct3_i})
                    {F7_STD, 3'b000}: dec_ctrl = ALU_ADD;
                    {F7_ALT, 3'b000}: dec_ctrl = ALU_SUB;
                    {F7_STD, 3'b001}: dec_ctrl = ALU_SLL;
                    {F7_STD, 3'b010}: dec_ctrl = ALU_SLT;
                    {F7_STD, 3'b011}: dec_ctrl = ALU_SLTU;
                    {F7_STD, 3'b100}: dec_ctrl = ALU_XOR;
                    {F7_STD, 3'b101}: dec_ctrl = ALU_SRL;
                    {F7_ALT, 3'b101}: dec_ctrl = ALU_SRA;
                    {F7_STD, 3'b110}: dec_ctrl = ALU_OR;
                    {F7_STD, 3'b111}: dec_ctrl = ALU_AND;
                    {7'b0000001, 3'b000}: begin
                        dec_ctrl = MUL_EN ? ALU_MUL : ALU_ADD;
                        dec_ill  = !MUL_EN;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
        endcase
    end

    assign load = !ex_q.valid || bus.out_ready_i;

    // Flush wins over load; bubbles clear controls but keep data.
    always_comb begin
        ex_d = ex_q;
        if (bus.flush_i) begin
            ex_d.valid = 1'b0;
            ex_d.mem   = 2'b00;
            ex_d.wb    = 1'b0;
            ex_d.ill   = 1'b0;
        end else if (load && bus.in_valid_i) begin
            ex_d.valid = 1'b1;
            ex_d.val1  = bus.rs1_data_i;
            ex_d.val2  = bus.rs2_data_i;
            ex_d.imm   = bus.imm_i;
            ex_d.rs1   = bus.rs1_addr_i;
            ex_d.rs2   = bus.rs2_addr_i;
            ex_d.rd    = bus.rd_addr_i;
            ex_d.ctrl  = dec_ctrl;
            ex_d.src   = bus.alu_src_i;
            ex_d.mem   = bus.mem_i;
            ex_d.wb    = bus.wb_i && !dec_ill;
            ex_d.ill   = dec_ill;
        end else if (load) begin
            ex_d.valid = 1'b0;
            ex_d.mem   = 2'b00;
            ex_d.wb    = 1'b0;
            ex_d.ill   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    assign bus.in_ready_o  = load;
    assign bus.out_valid_o = ex_q.valid;
    assign bus.val1_o      = ex_q.val1;
    assign bus.val2_o      = ex_q.val2;
    assign bus.imm_o       = ex_q.imm;
    assign bus.rs1_addr_o  = ex_q.rs1;
    assign bus.rs2_addr_o  = ex_q.rs2;
    assign bus.rd_addr_o   = ex_q.rd;
    assign bus.alu_ctrl_o  = ex_q.ctrl;
    assign bus.alu_src_o   = ex_q.src;
    assign bus.mem_o       = ex_q.mem;
    assign bus.wb_o        = ex_q.wb;
    assign bus.illegal_o   = ex_q.ill;
endmodule
